// File: rtl/alu_pkg.sv
// Shared definitions for the 6-bit ALU accumulator slice: opcodes, widths,
// FSM state encoding and a small flag helper.
package alu_pkg;

  localparam int ALU_WIDTH = 6;
  localparam int OP_WIDTH  = 2;

  localparam logic [OP_WIDTH-1:0] OP_LOAD = 2'd0;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 2'd1;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 2'd2;
  localparam logic [OP_WIDTH-1:0] OP_CLR  = 2'd3;

  // IDLE: no result pending downstream. HOLD: a result is presented.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_t;

  // Zero flag for a full-width accumulator value.
  function automatic logic is_zero(input logic [ALU_WIDTH-1:0] value);
    return (value == {ALU_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// Combinational ripple-carry add/subtract core.
// sel=0: sum = x + y. sel=1: sum = x - y (two's complement: x + ~y + 1).
// c_out is the carry out of the MSB (not-borrow when subtracting);
// overflow is carry into the MSB XOR carry out of the MSB.
module ripple_adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  logic [WIDTH-1:0] y_eff_s;
  logic [WIDTH:0]   carry_s;

  // Full-adder chain; the subtract select doubles as the initial carry-in.
  always_comb begin
    y_eff_s    = y ^ {WIDTH{sel}};
    carry_s    = {(WIDTH+1){1'b0}};
    sum        = {WIDTH{1'b0}};
    carry_s[0] = sel;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = x[i] ^ y_eff_s[i] ^ carry_s[i];
      carry_s[i+1] = (x[i] & y_eff_s[i]) | (carry_s[i] & (x[i] ^ y_eff_s[i]));
    end
    c_out    = carry_s[WIDTH];
    overflow = carry_s[WIDTH] ^ carry_s[WIDTH-1];
  end

endmodule

// File: rtl/alu_accumulator.sv
// Registered operand/accumulator stage around the 6-bit ripple_adder.
// One operation per in_valid/in_ready handshake; the result and flags are
// registered on acceptance and held on the out_valid/out_ready handshake.
// Optional build macro: STICKY_FLAGS_EN -- carry and overflow flags OR-accumulate
// across ADD/SUB results until a LOAD, CLR or reset clears them.
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = OP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  // The adder core and the opcode encoding are fixed; refuse other sizes.
  generate
    if (WIDTH != ALU_WIDTH) begin : g_bad_width
      $error("alu_accumulator: WIDTH must equal ALU_WIDTH (6)");
    end
    if (OP_W != OP_WIDTH) begin : g_bad_op_w
      $error("alu_accumulator: OP_W must equal OP_WIDTH (2)");
    end
  endgenerate

  acc_state_t       state_q;
  logic [WIDTH-1:0] acc_q;
  logic             flag_c_q;
  logic             flag_v_q;
  logic             flag_z_q;
  logic             flag_n_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] acc_d;
  logic             flag_c_d;
  logic             flag_v_d;
  logic             flag_z_d;
  logic             flag_n_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             sub_sel_s;
  logic [WIDTH-1:0] sum_s;
  logic             c_out_s;
  logic             ovf_s;

  // The adder always sees the current accumulator and the offered operand;
  // its outputs only matter on a cycle where the request is accepted.
  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x        (acc_q),
    .y        (in_operand),
    .sel      (sub_sel_s),
    .sum      (sum_s),
    .c_out    (c_out_s),
    .overflow (ovf_s)
  );

  // Handshake: a new request may enter whenever the held result is drained
  // this cycle (or nothing is held).
  always_comb begin
    in_ready_s = !out_valid_q || out_ready;
    accept_s   = in_valid && in_ready_s;
    sub_sel_s  = (in_op == OP_SUB);
  end

  // Next accumulator and flag values for the offered operation.
  always_comb begin
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    case (in_op)
      OP_LOAD: begin
        acc_d    = in_operand;
        flag_c_d = 1'b0;
        flag_v_d = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        acc_d = sum_s;
`ifdef STICKY_FLAGS_EN
        flag_c_d = c_out_s | flag_c_q;
        flag_v_d = ovf_s | flag_v_q;
`else
        flag_c_d = c_out_s;
        flag_v_d = ovf_s;
`endif
      end
      OP_CLR: begin
        acc_d    = {WIDTH{1'b0}};
        flag_c_d = 1'b0;
        flag_v_d = 1'b0;
      end
      default: begin
        acc_d    = acc_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
      end
    endcase
    flag_z_d = is_zero(acc_d);
    flag_n_d = acc_d[WIDTH-1];
  end

  // Result FSM: captures accepted results and holds them until drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      if (accept_s) begin
        acc_q    <= acc_d;
        flag_c_q <= flag_c_d;
        flag_v_q <= flag_v_d;
        flag_z_q <= flag_z_d;
        flag_n_q <= flag_n_d;
      end else begin
        acc_q    <= acc_q;
        flag_c_q <= flag_c_q;
        flag_v_q <= flag_v_q;
        flag_z_q <= flag_z_q;
        flag_n_q <= flag_n_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end else begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (accept_s) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator: an arithmetic reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_alu_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [5:0] in_operand;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] acc;
  logic       flag_c;
  logic       flag_v;
  logic       flag_z;
  logic       flag_n;

  int checks;
  int errors;

  alu_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_acc;
  int m_c;
  int m_v;
  int m_valid;

  // Returns {c, v, acc[5:0]} computed with plain integer arithmetic.
  function automatic logic [7:0] model_op(input int op, input int a, input int b,
                                          input int c_prev, input int v_prev);
    int sa, sb, r, c, v, res;
    sa = (a >= 32) ? a - 64 : a;
    sb = (b >= 32) ? b - 64 : b;
    c = 0; v = 0; res = 0;
    case (op)
      0: res = b;
      1: begin
        res = (a + b) % 64;
        c = (a + b >= 64) ? 1 : 0;
        r = sa + sb;
        v = (r > 31 || r < -32) ? 1 : 0;
      end
      2: begin
        res = (a - b + 64) % 64;
        c = (a >= b) ? 1 : 0;
        r = sa - sb;
        v = (r > 31 || r < -32) ? 1 : 0;
      end
      default: res = 0;
    endcase
`ifdef STICKY_FLAGS_EN
    if (op == 1 || op == 2) begin
      c = c | c_prev;
      v = v | v_prev;
    end
`else
    if (c_prev > 1 || v_prev > 1) res = res; // previous flags do not carry over
`endif
    return {c[0], v[0], res[5:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [7:0] r8;
    if (rst) begin
      m_acc   <= 0;
      m_c     <= 0;
      m_v     <= 0;
      m_valid <= 0;
    end else if (in_valid && (m_valid == 0 || out_ready)) begin
      r8 = model_op(int'(in_op), m_acc, int'(in_operand), m_c, m_v);
      m_acc   <= int'(r8[5:0]);
      m_c     <= int'(r8[7]);
      m_v     <= int'(r8[6]);
      m_valid <= 1;
    end else if (out_ready) begin
      m_valid <= 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), m_valid);
      chk("in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
      if (m_valid != 0) begin
        chk("acc", int'(acc), m_acc);
        chk("flag_c", int'(flag_c), m_c);
        chk("flag_v", int'(flag_v), m_v);
        chk("flag_z", int'(flag_z), (m_acc == 0) ? 1 : 0);
        chk("flag_n", int'(flag_n), (m_acc >= 32) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] val);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = val;
    step();
    in_valid   = 1'b0;
    in_operand = 6'h2A;
  endtask

  task automatic chk_res(input string tag, input int a, input int c, input int v,
                         input int z, input int n);
    chk({tag, "_acc"}, int'(acc), a);
    chk({tag, "_c"}, int'(flag_c), c);
    chk({tag, "_v"}, int'(flag_v), v);
    chk({tag, "_z"}, int'(flag_z), z);
    chk({tag, "_n"}, int'(flag_n), n);
    chk({tag, "_valid"}, int'(out_valid), 1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 2'd0;
    in_operand = 6'd0;
    out_ready  = 1'b1;
    step();
    step();
    chk("rst_acc", int'(acc), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    step();

    // Test 2: back-to-back LOAD then ADD.
    issue(2'd0, 6'h05);
    chk_res("load5", 5, 0, 0, 0, 0);
    issue(2'd1, 6'h03);
    chk_res("add3", 8, 0, 0, 0, 0);
    step();

    // Test 3: signed overflow into the MSB.
    issue(2'd0, 6'h1F);
    issue(2'd1, 6'h01);
    chk_res("ovf", 32, 0, 1, 0, 1);

    // Test 4: borrow and exact-zero subtraction.
    issue(2'd0, 6'h00);
    issue(2'd2, 6'h01);
    chk_res("borrow", 63, 0, 0, 0, 1);
    issue(2'd0, 6'h01);
    issue(2'd2, 6'h01);
    chk_res("subzero", 0, 1, 0, 1, 0);

    // Extra wrap: 0x3F + 0x01 -> 0, carry out, no signed overflow.
    issue(2'd0, 6'h3F);
    issue(2'd1, 6'h01);
    chk_res("wrap", 0, 1, 0, 1, 0);
    step();

    // Test 5: backpressure with a pending request.
    issue(2'd0, 6'h0A);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_op      = 2'd1;
    in_operand = 6'h02;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_acc", int'(acc), 10);
      chk("bp_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk_res("bp_add", 12, 0, 0, 0, 0);
    step();
    chk("drained", int'(out_valid), 0);

    // Test 6: sticky vs per-result overflow.
    issue(2'd0, 6'h1F);
    issue(2'd1, 6'h01);
    issue(2'd1, 6'h00);
`ifdef STICKY_FLAGS_EN
    chk_res("sticky_add0", 32, 0, 1, 0, 1);
`else
    chk_res("sticky_add0", 32, 0, 0, 0, 1);
`endif
    issue(2'd3, 6'h15);
    chk_res("clr", 0, 0, 0, 1, 0);
    step();

    // Test 1: async reset while a result is held.
    out_ready = 1'b0;
    issue(2'd0, 6'h15);
    chk("pre_rst_valid", int'(out_valid), 1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_acc", int'(acc), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_flags", int'({flag_c, flag_v, flag_z, flag_n}), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    issue(2'd1, 6'h07);
    chk_res("post_rst_add", 7, 0, 0, 0, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
